valid_ram: RTL
==============

VALID_RAM -- requirements
Module: valid_ram

Interface
REQ-001 SHALL have parameter A, default 9, address width; depth is 2^A entries.
REQ-002 SHALL have parameter S, default 24, data word width.
REQ-003 SHALL have parameter L, default 3, lane count; S SHALL be divisible by L, each lane S/L bits.
REQ-004 SHALL have port clock  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports wr_en in 1, wr_addr in A, wr_data in S, and wr_lane_en in L (per-lane write enable).
REQ-007 SHALL have ports rd_en in 1, rd_addr in A, rd_data out S, rd_hit out 1 (entry valid), and rd_ack out 1 (read result strobe).
REQ-008 SHALL have ports clr_start in 1, clr_base in A, clr_count in A+1, clr_busy out 1, and clr_done out 1.
REQ-009 SHALL have port occupancy  out  A+1  count of valid entries.

Function
REQ-010 SHALL keep one valid bit per entry; all entries SHALL power up and reset invalid.
REQ-011 Read latency SHALL be 1 cycle: rd_en at edge N -> rd_ack=1 after edge N+1 for exactly one cycle.
REQ-012 On a read, rd_data SHALL return the stored word and rd_hit=1 if the entry is valid, else rd_data=0 and rd_hit=0.
REQ-013 rd_data and rd_hit SHALL hold their last values while rd_en=0.
REQ-014 A write SHALL update only the lanes with wr_lane_en=1 and set the entry valid.
REQ-015 A write to an invalid entry SHALL store 0 in the disabled lanes.
REQ-016 wr_en=1 with wr_lane_en=0 SHALL be a no-op; the valid bit SHALL be unchanged.
REQ-017 A same-cycle read and write to the same address SHALL return the pre-write contents and valid state (see REQ-030 for the alternative).
REQ-018 The clear FSM SHALL have states IDLE and CLEAR; clr_busy=1 exactly in CLEAR.
REQ-019 clr_start in IDLE with clr_count>0 SHALL enter CLEAR and invalidate one entry per cycle, starting at clr_base.
REQ-020 Clear addresses SHALL wrap modulo 2^A.
REQ-021 clr_count values above 2^A SHALL be clamped to 2^A.
REQ-022 After the last entry is cleared, the FSM SHALL return to IDLE and pulse clr_done for one cycle.
REQ-023 clr_start with clr_count=0 SHALL pulse clr_done the next cycle without entering CLEAR.
REQ-024 clr_start while in CLEAR SHALL be ignored.
REQ-025 Reads and writes SHALL remain operational during CLEAR.
REQ-026 If a write and the clear sweep hit the same address in the same cycle, the clear SHALL win and the entry SHALL end invalid.
REQ-027 occupancy SHALL increment when an invalid entry becomes valid, decrement when a valid entry is invalidated, and hold on any simultaneous same-entry net-zero event; it SHALL never wrap.

Reset
REQ-028 reset SHALL, in one cycle, invalidate all entries and force occupancy=0, FSM=IDLE, rd_data=0, rd_hit=0, rd_ack=0, clr_busy=0, and clr_done=0; stored data words SHALL NOT need clearing.
REQ-029 reset during CLEAR SHALL abort the sweep with no clr_done pulse; reset SHALL take priority over all same-cycle wr_en, rd_en, and clr_start.

Configuration
REQ-030 With macro VALID_RAM_BYPASS_EN defined, a same-cycle read and write to the same address SHALL return the merged post-write word with rd_hit=1 (clear still wins per REQ-026); without it, REQ-017 SHALL apply.

Verification
REQ-031 Reset, then read addr 5 -> next cycle rd_ack=1, rd_hit=0, rd_data=0, occupancy=0.
REQ-032 Write 0xAABBCC with lanes 3'b010 to invalid addr 7, then read addr 7 -> rd_data=0x00BB00, rd_hit=1, occupancy=1.
REQ-033 Write 0x112233 to addr 3, read addr 3 with same-cycle write 0x445566 -> 0x112233 without macro, 0x445566 with VALID_RAM_BYPASS_EN.
REQ-034 Fill addrs 510, 511, 0, 1 (A=9), then clr_base=510, clr_count=3 -> clr_busy for 3 cycles, clr_done pulse, addrs 510/511/0 invalid, addr 1 valid, occupancy=1.
REQ-035 Start clr_count=100, assert reset at sweep cycle 40 -> no clr_done, clr_busy=0, occupancy=0, all reads rd_hit=0.
REQ-036 During a sweep, write addr equal to the current sweep address -> entry reads rd_hit=0 and occupancy is unchanged by that write.

Source files
------------

// File: rtl/valid_ram_if.sv
// Bus bundle for valid_ram: write port, read port, clear-sweep control and occupancy.
// The master modport drives requests and the slave modport (the RAM) returns results.
interface valid_ram_if #(
  parameter int A = 9,
  parameter int S = 24,
  parameter int L = 3
);
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [S-1:0] wr_data;
  logic [L-1:0] wr_lane_en;

  logic         rd_en;
  logic [A-1:0] rd_addr;
  logic [S-1:0] rd_data;
  logic         rd_hit;
  logic         rd_ack;

  logic         clr_start;
  logic [A-1:0] clr_base;
  logic [A:0]   clr_count;
  logic         clr_busy;
  logic         clr_done;

  logic [A:0]   occupancy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_lane_en,
    output rd_en, rd_addr,
    input  rd_data, rd_hit, rd_ack,
    output clr_start, clr_base, clr_count,
    input  clr_busy, clr_done,
    input  occupancy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_lane_en,
    input  rd_en, rd_addr,
    output rd_data, rd_hit, rd_ack,
    input  clr_start, clr_base, clr_count,
    output clr_busy, clr_done,
    output occupancy
  );
endinterface

// File: rtl/valid_ram.sv
// Lane-writable RAM with per-entry valid bits, a background clear sweep and an occupancy count.
// Define VALID_RAM_BYPASS_EN to forward a same-cycle same-address write into the read result.
module valid_ram #(
  parameter int A = 9,
  parameter int S = 24,
  parameter int L = 3
) (
  input logic       clock,
  input logic       reset,
  valid_ram_if.slave bus
);
  localparam int         W         = S / L;
  localparam int         DEPTH     = 1 << A;
  localparam logic [A:0] DEPTH_CNT = DEPTH[A:0];
  localparam logic [A:0] ONE_CNT   = {{A{1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t           state_reg, state_next;
  logic [A-1:0]     clr_addr_reg, clr_addr_next;
  logic [A:0]       clr_left_reg, clr_left_next;
  logic             clr_done_reg, clr_done_next;
  logic             sweep_active;

  logic [DEPTH-1:0] valid_reg;
  logic [A:0]       occupancy_reg, occupancy_next;
  logic             occ_inc, occ_dec;

  logic             wr_active, sweep_hit, wr_commit, wr_entry_valid;

  logic             rd_ack_reg;
  logic             rd_valid_reg;
  logic [L-1:0]     rd_byp_lanes_reg, byp_lanes_next;
  logic [S-1:0]     rd_byp_data_reg;
  logic [S-1:0]     rd_data_mux;

  // ---------------- clear FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      clr_addr_reg <= '0;
      clr_left_reg <= '0;
      clr_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
      clr_left_reg <= clr_left_next;
      clr_done_reg <= clr_done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    clr_left_next = clr_left_reg;
    clr_done_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.clr_start) begin
          if (bus.clr_count == '0) begin
            clr_done_next = 1'b1;
          end else begin
            state_next    = ST_CLEAR;
            clr_addr_next = bus.clr_base;
            clr_left_next = (bus.clr_count > DEPTH_CNT) ? DEPTH_CNT : bus.clr_count;
          end
        end
      end
      ST_CLEAR: begin
        // Address counter is A bits wide, so the sweep wraps naturally.
        clr_addr_next = clr_addr_reg + 1'b1;
        clr_left_next = clr_left_reg - ONE_CNT;
        if (clr_left_reg == ONE_CNT) begin
          state_next    = ST_IDLE;
          clr_done_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sweep_active = (state_reg == ST_CLEAR);
  end

  assign bus.clr_busy = sweep_active;
  assign bus.clr_done = clr_done_reg;

  // ---------------- write qualification ----------------
  assign wr_active      = bus.wr_en && (|bus.wr_lane_en) && !reset;
  assign sweep_hit      = sweep_active && (clr_addr_reg == bus.wr_addr);
  assign wr_commit      = wr_active && !sweep_hit;
  assign wr_entry_valid = valid_reg[bus.wr_addr];

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= '0;
    end else begin
      if (wr_commit) begin
        valid_reg[bus.wr_addr] <= 1'b1;
      end
      if (sweep_active) begin
        valid_reg[clr_addr_reg] <= 1'b0;
      end
    end
  end

  // A write never lands on the swept entry, so both events can be counted independently.
  always_comb begin
    occ_inc        = wr_commit && !wr_entry_valid;
    occ_dec        = sweep_active && valid_reg[clr_addr_reg];
    occupancy_next = occupancy_reg;
    if (occ_inc && !occ_dec) begin
      occupancy_next = occupancy_reg + ONE_CNT;
    end else if (!occ_inc && occ_dec) begin
      occupancy_next = occupancy_reg - ONE_CNT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occupancy_reg <= '0;
    end else begin
      occupancy_reg <= occupancy_next;
    end
  end

  assign bus.occupancy = occupancy_reg;

  // ---------------- read side ----------------
`ifdef VALID_RAM_BYPASS_EN
  assign byp_lanes_next = (wr_commit && (bus.wr_addr == bus.rd_addr)) ? bus.wr_lane_en : '0;
`else
  assign byp_lanes_next = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ack_reg       <= 1'b0;
      rd_valid_reg     <= 1'b0;
      rd_byp_lanes_reg <= '0;
    end else begin
      rd_ack_reg <= bus.rd_en;
      if (bus.rd_en) begin
        rd_valid_reg     <= valid_reg[bus.rd_addr];
        rd_byp_lanes_reg <= byp_lanes_next;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (bus.rd_en) begin
      rd_byp_data_reg <= bus.wr_data;
    end
  end

  // One RAM per lane; an invalid entry gets every lane rewritten so disabled lanes read 0.
  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_lane
      logic [W-1:0] mem [DEPTH];
      logic [W-1:0] rd_word_reg;
      logic         lane_we;
      logic [W-1:0] lane_wdata;

      assign lane_we    = wr_commit && (bus.wr_lane_en[gi] || !wr_entry_valid);
      assign lane_wdata = bus.wr_lane_en[gi] ? bus.wr_data[gi*W +: W] : '0;

      always_ff @(posedge clock) begin
        if (lane_we) begin
          mem[bus.wr_addr] <= lane_wdata;
        end
        if (bus.rd_en) begin
          rd_word_reg <= mem[bus.rd_addr];
        end
      end

      assign rd_data_mux[gi*W +: W] = rd_byp_lanes_reg[gi] ? rd_byp_data_reg[gi*W +: W] :
                                      (rd_valid_reg ? rd_word_reg : '0);
    end
  endgenerate

  assign bus.rd_data = rd_data_mux;
  assign bus.rd_hit  = rd_valid_reg || (|rd_byp_lanes_reg);
  assign bus.rd_ack  = rd_ack_reg;

endmodule
